// File: rtl/rv32_pkg.sv
// rv32_pkg: shared widths, NOP encoding and fetch-memory state type for the RV32I core
package rv32_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic {RUN, LOAD} state_t;
endpackage

// File: rtl/instr_mem_sync_if.sv
// instr_mem_sync_if: fetch handshake and sequential load port of the instruction memory
interface instr_mem_sync_if;
    import rv32_pkg::*;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ILEN-1:0] rsp_instr;
    logic [XLEN-1:0] rsp_addr;
    logic            rsp_fault;
    logic            load_start;
    logic            load_we;
    logic [ILEN-1:0] load_data;
    logic            load_done;
    logic            busy;
    modport master (
        output req_valid, req_addr, flush, rsp_ready, load_start, load_we, load_data, load_done,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault, busy
    );
    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, load_start, load_we, load_data, load_done,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault, busy
    );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: single-port word array with synchronous read, write enable and no reset
module imem_ram #(
    parameter int              DEPTH = 256,
    parameter int              W     = 32,
    parameter logic [W-1:0]    INIT  = '0,
    parameter int              IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata
);
    logic [W-1:0] mem [DEPTH] = '{default: INIT};
    // write takes the port when enabled; read data register only moves on a read so it holds through stalls
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous-read instruction memory with fetch handshake, flush and run-time load port
module instr_mem_sync
    import rv32_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input logic              clk,
    input logic              rst,
    instr_mem_sync_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    state_t          state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, ram_addr;
    logic            rsp_valid, rsp_valid_n, rsp_fault, rd_ok, accept, fault, we;
    logic [XLEN-1:0] rsp_addr;
    logic [ILEN-1:0] rdata;
    assign fault         = |bus.req_addr[1:0] || |bus.req_addr[XLEN-1:IDX_W+2];
    assign bus.req_ready = state == RUN && !bus.load_start && !bus.flush && (!rsp_valid || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign we            = state == LOAD && bus.load_we;
    assign ram_addr      = we ? ptr : bus.req_addr[IDX_W+1:2];
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_addr  = rsp_addr;
    assign bus.rsp_fault = rsp_fault;
    assign bus.rsp_instr = rd_ok ? rdata : NOP_INSTR;
    assign bus.busy      = state == LOAD;
    imem_ram #(.DEPTH(DEPTH), .W(ILEN), .INIT(NOP_INSTR)) u_ram (
        .clk  (clk),
        .we   (we),
        .re   (accept && !fault),
        .addr (ram_addr),
        .wdata(bus.load_data),
        .rdata(rdata)
    );
    // next state: load_start wins; LOAD exits on load_done or on writing the last word (pointer wraps)
    always_comb begin
        state_n     = bus.load_start ? LOAD
                    : (state == LOAD && (bus.load_done || (we && ptr == IDX_W'(DEPTH - 1)))) ? RUN
                    : state;
        ptr_n       = bus.load_start ? '0 : we ? ptr + 1'b1 : ptr;
        rsp_valid_n = (bus.load_start || state == LOAD) ? 1'b0
                    : accept ? 1'b1
                    : (bus.flush || bus.rsp_ready) ? 1'b0
                    : rsp_valid;
    end
    // state, pointer and response registers; address/fault only move on an accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_fault <= 1'b0;
            rd_ok     <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            rsp_valid <= rsp_valid_n;
            if (accept) begin
                rsp_addr  <= bus.req_addr;
                rsp_fault <= fault;
                rd_ok     <= !fault;
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed self-checking bench for instr_mem_sync
module tb_instr_mem_sync;
    localparam int DEPTH = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0 = 32'h00A0_0213;
    localparam logic [31:0] W1 = 32'h0002_0E63;
    localparam logic [31:0] W2 = 32'hFFF2_0213;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    instr_mem_sync_if bus();
    instr_mem_sync #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] pat(input int i);
        return (i == 2) ? NOP : 32'h1000_0000 + i;
    endfunction
    initial begin
        bus.req_valid = 0; bus.req_addr = 0; bus.flush = 0; bus.rsp_ready = 0;
        bus.load_start = 0; bus.load_we = 0; bus.load_data = 0; bus.load_done = 0;
        #3;
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_instr", bus.rsp_instr, NOP);
        check("rst_addr", bus.rsp_addr, 0);
        check("rst_fault", bus.rsp_fault, 0);
        check("rst_busy", bus.busy, 0);
        tick();
        rst = 0;
        tick();
        // 1: load three words, fetch them back-to-back
        bus.load_start = 1;
        tick();
        bus.load_start = 0;
        #1;
        check("load_busy", bus.busy, 1);
        check("load_rdy", bus.req_ready, 0);
        bus.load_we = 1; bus.load_data = W0; tick();
        bus.load_data = W1; tick();
        bus.load_data = W2; tick();
        bus.load_we = 0; bus.load_done = 1; tick();
        bus.load_done = 0;
        check("done_busy", bus.busy, 0);
        bus.req_valid = 1; bus.req_addr = 0; bus.rsp_ready = 1;
        #1;
        check("t1_rdy", bus.req_ready, 1);
        tick();
        check("t1_v0", bus.rsp_valid, 1);
        check("t1_i0", bus.rsp_instr, W0);
        check("t1_a0", bus.rsp_addr, 0);
        bus.req_addr = 4; tick();
        check("t1_v1", bus.rsp_valid, 1);
        check("t1_i1", bus.rsp_instr, W1);
        check("t1_a1", bus.rsp_addr, 4);
        bus.req_addr = 8; tick();
        check("t1_i2", bus.rsp_instr, W2);
        check("t1_a2", bus.rsp_addr, 8);
        bus.req_valid = 0; tick();
        check("t1_drain", bus.rsp_valid, 0);
        // 2: stall holds the response, release accepts the next request same cycle
        bus.req_valid = 1; bus.req_addr = 4; bus.rsp_ready = 0;
        tick();
        bus.req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_rdy", bus.req_ready, 0);
            check("t2_hold", bus.rsp_instr, W1);
            check("t2_valid", bus.rsp_valid, 1);
            tick();
        end
        bus.req_valid = 1; bus.req_addr = 8; bus.rsp_ready = 1;
        #1;
        check("t2_rel_rdy", bus.req_ready, 1);
        tick();
        check("t2_next", bus.rsp_instr, W2);
        check("t2_next_a", bus.rsp_addr, 8);
        bus.req_valid = 0; tick();
        check("t2_drain", bus.rsp_valid, 0);
        // 3: misaligned and out-of-range faults
        bus.req_valid = 1; bus.req_addr = 6; tick();
        check("t3_mis_f", bus.rsp_fault, 1);
        check("t3_mis_i", bus.rsp_instr, NOP);
        check("t3_mis_a", bus.rsp_addr, 6);
        bus.req_addr = 4 * DEPTH; tick();
        check("t3_oor_f", bus.rsp_fault, 1);
        check("t3_oor_i", bus.rsp_instr, NOP);
        bus.req_addr = 0; tick();
        check("t3_ok_f", bus.rsp_fault, 0);
        check("t3_ok_i", bus.rsp_instr, W0);
        bus.req_valid = 0; tick();
        // 4: flush drops the held response and the same-cycle request
        bus.req_valid = 1; bus.req_addr = 4; bus.rsp_ready = 0; tick();
        check("t4_pend", bus.rsp_valid, 1);
        bus.flush = 1; bus.req_addr = 8;
        #1;
        check("t4_rdy", bus.req_ready, 0);
        tick();
        bus.flush = 0; bus.req_valid = 0;
        check("t4_v0", bus.rsp_valid, 0);
        tick();
        check("t4_v1", bus.rsp_valid, 0);
        check("t4_addr", bus.rsp_addr, 4);
        // 5: full-depth load exits LOAD by itself
        bus.rsp_ready = 1;
        bus.load_start = 1; tick();
        bus.load_start = 0; bus.load_we = 1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.load_data = pat(i);
            tick();
            if (i == DEPTH - 2) check("t5_busy_mid", bus.busy, 1);
        end
        bus.load_we = 0;
        check("t5_busy_end", bus.busy, 0);
        bus.req_valid = 1; bus.req_addr = 4 * (DEPTH - 1); tick();
        check("t5_last", bus.rsp_instr, pat(DEPTH - 1));
        check("t5_last_f", bus.rsp_fault, 0);
        bus.req_addr = 4; tick();
        check("t5_w1", bus.rsp_instr, pat(1));
        bus.req_valid = 0; tick();
        // 6: asynchronous reset in the middle of a load
        bus.load_start = 1; tick();
        bus.load_start = 0; bus.load_we = 1;
        bus.load_data = 32'hAAAA_0001; tick();
        bus.load_data = 32'hBBBB_0002; tick();
        bus.load_we = 0;
        check("t6_busy", bus.busy, 1);
        #2 rst = 1;
        #1;
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_valid", bus.rsp_valid, 0);
        rst = 0;
        bus.req_valid = 1; bus.req_addr = 4; tick();
        check("t6_w1", bus.rsp_instr, 32'hBBBB_0002);
        bus.req_addr = 8; tick();
        check("t6_w2", bus.rsp_instr, NOP);
        bus.req_addr = 0; tick();
        check("t6_w0", bus.rsp_instr, 32'hAAAA_0001);
        bus.req_valid = 0; tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
